// File: rtl/inv_bank.sv
// ==== inv_bank: synchronised, debounced, polarity-programmable channel bank (rev 1.0) ====
`default_nettype none

module inv_bank #(
  parameter int WIDTH = 8,
  parameter int FILT  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_mode,
  input  logic [WIDTH-1:0] cfg_pol,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_chg,
  output logic [1:0]       mode
);

  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [CW-1:0] C_CNT_MAX = CW'(FILT - 1);
  localparam logic [CW-1:0] C_CNT_ONE = CW'(1);

  localparam logic [1:0] C_MODE_PASS   = 2'b00;
  localparam logic [1:0] C_MODE_TOGGLE = 2'b01;
  localparam logic [1:0] C_MODE_PULSE  = 2'b10;

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] w_stb;
  logic [WIDTH-1:0] r_stb_d;
  logic [WIDTH-1:0] r_t;
  logic [WIDTH-1:0] r_pol;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_t_next;
  logic [WIDTH-1:0] w_out_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= in;
      r_s2 <= r_s1;
    end
  end

  // Each channel owns its counter and debounced level so channels never interact.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [CW-1:0] r_cnt;
    logic          r_stb;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
        r_stb <= 1'b0;
      end else if (r_s2[i] == r_stb) begin
        r_cnt <= '0;
      end else if (r_cnt == C_CNT_MAX) begin
        r_stb <= r_s2[i];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + C_CNT_ONE;
      end
    end

    assign w_stb[i] = r_stb;
  end

  always_comb begin
    w_rise     = w_stb & ~r_stb_d;
    w_t_next   = r_t ^ w_rise;
    w_out_next = out;
    case (r_mode)
      C_MODE_PASS:   w_out_next = w_stb ^ r_pol;
      C_MODE_TOGGLE: w_out_next = w_t_next ^ r_pol;
      C_MODE_PULSE:  w_out_next = w_rise ^ r_pol;
      default:       w_out_next = out;
    endcase
  end

  // A config write clears toggle state and wins over a coincident rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stb_d <= '0;
      r_t     <= '0;
      r_pol   <= '0;
      r_mode  <= C_MODE_PASS;
      out     <= '0;
      out_chg <= '0;
    end else begin
      r_stb_d <= w_stb;
      out     <= w_out_next;
      out_chg <= w_out_next ^ out;
      if (cfg_we) begin
        r_mode <= cfg_mode;
        r_pol  <= cfg_pol;
        r_t    <= '0;
      end else begin
        r_t    <= w_t_next;
      end
    end
  end

  assign mode = r_mode;

endmodule

`default_nettype wire

// File: tb/tb_inv_bank.sv
// ==== tb_inv_bank: directed self-checking bench for inv_bank (rev 1.0) ====
`default_nettype none

module tb_inv_bank;

  logic       clk;
  logic       rst;
  logic [7:0] in;
  logic       cfg_we;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_pol;
  logic [7:0] out;
  logic [7:0] out_chg;
  logic [1:0] mode;

  int n_assert = 0;
  int n_fail   = 0;

  inv_bank #(.WIDTH(8), .FILT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .cfg_we   (cfg_we),
    .cfg_mode (cfg_mode),
    .cfg_pol  (cfg_pol),
    .out      (out),
    .out_chg  (out_chg),
    .mode     (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic write_cfg(input logic [1:0] m, input logic [7:0] p);
    cfg_we   = 1'b1;
    cfg_mode = m;
    cfg_pol  = p;
    tick(1);
    cfg_we   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in = 8'hFF; cfg_we = 1'b0; cfg_mode = 2'b00; cfg_pol = 8'h00;

    // Reset with all inputs high
    tick(3);
    check("rst_out", out, 8'h00);
    check("rst_chg", out_chg, 8'h00);
    check("rst_mode", {6'd0, mode}, 8'h00);

    // Release: first sampling edge k, out appears at k+6
    rst = 1'b0;
    tick(6);
    check("rel_out_k5", out, 8'h00);
    tick(1);
    check("rel_out_k6", out, 8'hFF);
    check("rel_chg_k6", out_chg, 8'hFF);
    tick(1);
    check("rel_chg_k7", out_chg, 8'h00);

    in = 8'h00;
    tick(10);
    check("idle_out", out, 8'h00);

    // Glitch of 3 cycles rejected
    in = 8'h01;
    tick(3);
    in = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("glitch_out", out, 8'h00);
    end

    // 4 stable cycles accepted, out at k+6
    in = 8'h01;
    tick(4);
    in = 8'h00;
    tick(2);
    check("filt4_k5", out, 8'h00);
    tick(1);
    check("filt4_k6", out, 8'h01);
    check("filt4_chg", out_chg, 8'h01);
    tick(4);
    check("filt4_fall", out, 8'h00);

    // Polarity in PASS mode
    write_cfg(2'b00, 8'h0F);
    check("pol_mode", {6'd0, mode}, 8'h00);
    check("pol_out_c", out, 8'h00);
    tick(1);
    check("pol_out_c1", out, 8'h0F);
    check("pol_chg_c1", out_chg, 8'h0F);
    in = 8'hFF;
    tick(6);
    check("pol_ff_k5", out, 8'h0F);
    tick(1);
    check("pol_ff_k6", out, 8'hF0);
    check("pol_ff_chg", out_chg, 8'hFF);
    in = 8'h00;
    tick(8);
    check("pol_00", out, 8'h0F);

    // TOGGLE: three presses on channel 3
    write_cfg(2'b01, 8'h00);
    check("tog_mode", {6'd0, mode}, 8'h01);
    tick(1);
    check("tog_start", out, 8'h00);
    in = 8'h08; tick(7);
    check("tog_p1", out, 8'h08);
    check("tog_p1_chg", out_chg, 8'h08);
    in = 8'h00; tick(8);
    check("tog_r1", out, 8'h08);
    in = 8'h08; tick(7);
    check("tog_p2", out, 8'h00);
    in = 8'h00; tick(8);
    check("tog_r2", out, 8'h00);
    in = 8'h08; tick(7);
    check("tog_p3", out, 8'h08);
    in = 8'h00; tick(8);
    check("tog_r3", out, 8'h08);

    // PULSE with channel 2 inverted
    write_cfg(2'b10, 8'h04);
    check("pul_mode", {6'd0, mode}, 8'h02);
    tick(1);
    check("pul_idle", out, 8'h04);
    check("pul_idle_chg", out_chg, 8'h0C);
    in = 8'h04;
    tick(6);
    check("pul_k5", out, 8'h04);
    tick(1);
    check("pul_k6", out, 8'h00);
    check("pul_k6_chg", out_chg, 8'h04);
    tick(1);
    check("pul_k7", out, 8'h04);
    check("pul_k7_chg", out_chg, 8'h04);
    tick(1);
    check("pul_k8", out, 8'h04);
    check("pul_k8_chg", out_chg, 8'h00);
    in = 8'h00;
    tick(8);

    // Config write on the same edge as rise[1]
    in = 8'h02;
    tick(6);
    write_cfg(2'b01, 8'h00);
    check("col_mode", {6'd0, mode}, 8'h01);
    check("col_out_c", out, 8'h06);
    tick(1);
    check("col_out_c1", out, 8'h00);
    check("col_chg_c1", out_chg, 8'h06);
    in = 8'h00;
    tick(8);
    check("col_hold", out, 8'h00);

    // Build t = AA, then reset mid-debounce
    in = 8'hAA;
    tick(7);
    check("aa_out", out, 8'hAA);
    in = 8'h00;
    tick(3);
    rst = 1'b1;
    #1;
    check("arst_out", out, 8'h00);
    check("arst_chg", out_chg, 8'h00);
    check("arst_mode", {6'd0, mode}, 8'h00);
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("post_rst_out", out, 8'h00);
    end
    check("post_rst_chg", out_chg, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
